// File: rtl/gray_quad_if.sv
// gray_quad_if: control inputs and position/status outputs of the Gray quadrature decoder.
interface gray_quad_if #(
    parameter int CNT_W = 8,
    parameter int ERR_W = 4
);
    logic             en_i;
    logic [1:0]       gray_i;
    logic             clr_err_i;
    logic [CNT_W-1:0] pos_o;
    logic             dir_o;
    logic             step_o;
    logic [1:0]       phase_o;
    logic             err_o;
    logic [ERR_W-1:0] err_cnt_o;
    modport master (output en_i, gray_i, clr_err_i, input pos_o, dir_o, step_o, phase_o, err_o, err_cnt_o);
    modport slave (input en_i, gray_i, clr_err_i, output pos_o, dir_o, step_o, phase_o, err_o, err_cnt_o);
endinterface

// File: rtl/gray_quad_decoder.sv
// gray_quad_decoder: synchronises a 2-bit Gray phase, tracks a wrapping position and flags illegal jumps.
module gray_quad_decoder #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_W       = 4
) (
    input logic        clk,
    input logic        rst,
    gray_quad_if.slave bus
);
    localparam int PW = $clog2(SYNC_STAGES + 1);
    logic [1:0]       sync_q [SYNC_STAGES];
    logic [1:0]       prev_q;
    logic             primed_q;
    logic [PW-1:0]    pcnt_q;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    logic [1:0]       phase_q;
    logic             err_q, err_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;
    logic [1:0]       g_s, b_s, b_prev, delta;
    logic             eval, fwd, bwd, ill;
    assign g_s    = sync_q[SYNC_STAGES-1];
    assign b_s    = {g_s[1], ^g_s};
    assign b_prev = {prev_q[1], ^prev_q};
    assign delta  = b_s - b_prev;
    assign eval   = primed_q & bus.en_i;
    assign fwd    = eval & (delta == 2'd1);
    assign bwd    = eval & (delta == 2'd3);
    assign ill    = eval & (delta == 2'd2);
    always_comb begin
        pos_d  = fwd ? pos_q + 1'b1 : bwd ? pos_q - 1'b1 : pos_q;
        dir_d  = (fwd | bwd) ? fwd : dir_q;
        step_d = fwd | bwd;
        err_d  = ill | (err_q & ~bus.clr_err_i);
        // an illegal step in the same cycle as a clear wins and restarts the count at one
        cnt_d  = ill ? (bus.clr_err_i ? ERR_W'(1) : (&cnt_q ? cnt_q : cnt_q + 1'b1)) :
                 bus.clr_err_i ? '0 : cnt_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 2'b00;
            prev_q   <= 2'b00;
            primed_q <= 1'b0;
            pcnt_q   <= '0;
            pos_q    <= '0;
            dir_q    <= 1'b1;
            step_q   <= 1'b0;
            phase_q  <= 2'b00;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q[0] <= bus.gray_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            if (!primed_q) begin
                pcnt_q   <= pcnt_q + 1'b1;
                primed_q <= (pcnt_q == PW'(SYNC_STAGES));
            end
            prev_q  <= g_s;
            phase_q <= b_s;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end
    assign bus.pos_o     = pos_q;
    assign bus.dir_o     = dir_q;
    assign bus.step_o    = step_q;
    assign bus.phase_o   = phase_q;
    assign bus.err_o     = err_q;
    assign bus.err_cnt_o = cnt_q;
endmodule

// File: tb/tb_gray_quad_decoder.sv
// tb_gray_quad_decoder: directed and random phase walks checked every cycle against a sample-history model.
module tb_gray_quad_decoder;
    localparam int S = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    gray_quad_if #(.CNT_W(8), .ERR_W(4)) bus ();
    gray_quad_decoder #(.CNT_W(8), .SYNC_STAGES(S), .ERR_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    int total = 0;
    int bad = 0;
    logic [1:0] codes [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic [1:0] samp [$];
    int edges, m_prev, m_pos, m_dir, m_step, m_phase, m_err, m_cnt, gi;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask
    function automatic int g2b(input logic [1:0] g);
        for (int i = 0; i < 4; i++) if (codes[i] == g) return i;
        return 0;
    endfunction
    task automatic model_reset();
        samp.delete();
        edges = 0; m_prev = 0; m_pos = 0; m_dir = 1; m_step = 0;
        m_phase = 0; m_err = 0; m_cnt = 0;
    endtask
    task automatic model_step();
        int b, d;
        bit ill;
        b = (samp.size() >= S) ? g2b(samp[samp.size()-S]) : 0;
        edges++;
        m_step = 0;
        ill = 0;
        if (edges > S + 1 && bus.en_i) begin
            d = (b - m_prev + 4) % 4;
            if (d == 1) begin m_pos = (m_pos + 1) % 256; m_dir = 1; m_step = 1; end
            if (d == 3) begin m_pos = (m_pos + 255) % 256; m_dir = 0; m_step = 1; end
            ill = (d == 2);
        end
        if (bus.clr_err_i) begin m_err = 0; m_cnt = 0; end
        if (ill) begin m_err = 1; m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15; end
        m_prev = b;
        m_phase = b;
        samp.push_back(bus.gray_i);
    endtask
    task automatic check_all();
        chk("pos", bus.pos_o, m_pos);
        chk("dir", bus.dir_o, m_dir);
        chk("step", bus.step_o, m_step);
        chk("phase", bus.phase_o, m_phase);
        chk("err", bus.err_o, m_err);
        chk("err_cnt", bus.err_cnt_o, m_cnt);
    endtask
    task automatic tick();
        @(posedge clk);
        model_step();
        #1 check_all();
    endtask
    task automatic go(input int idx, input int n);
        gi = idx & 3;
        bus.gray_i = codes[gi];
        repeat (n) tick();
    endtask
    task automatic do_reset(input int idx);
        #2 rst = 1'b1;
        gi = idx & 3;
        bus.gray_i = codes[gi];
        #1 model_reset();
        chk("rst_pos", bus.pos_o, 0);
        chk("rst_dir", bus.dir_o, 1);
        chk("rst_err", bus.err_o, 0);
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask
    initial begin
        int r;
        bus.en_i = 1'b1;
        bus.gray_i = 2'b00;
        bus.clr_err_i = 1'b0;
        gi = 0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        go(0, 6);
        for (int i = 1; i <= 4; i++) go(i, 4);
        chk("fwd_pos", bus.pos_o, 4);
        do_reset(0);
        go(0, 6);
        go(3, 4);
        go(2, 4);
        chk("bwd_pos", bus.pos_o, 8'hfe);
        chk("bwd_dir", bus.dir_o, 0);
        for (int i = 0; i < 6; i++) go(gi + 1, 4);
        chk("wrap_pos", bus.pos_o, 4);
        do_reset(2);
        go(2, 8);
        chk("prime_pos", bus.pos_o, 0);
        chk("prime_err", bus.err_o, 0);
        go(3, 4);
        chk("prime_step", bus.pos_o, 1);
        go(0, 4);
        go(2, 4);
        chk("ill_err", bus.err_o, 1);
        chk("ill_cnt", bus.err_cnt_o, 1);
        chk("ill_pos", bus.pos_o, 2);
        go(3, 4);
        chk("resync_pos", bus.pos_o, 3);
        for (int i = 0; i < 20; i++) go(gi + 2, 3);
        go(gi, 2);
        chk("sat_cnt", bus.err_cnt_o, 15);
        bus.clr_err_i = 1'b1;
        tick();
        bus.clr_err_i = 1'b0;
        tick();
        chk("clr_cnt", bus.err_cnt_o, 0);
        go(gi + 2, S);
        bus.clr_err_i = 1'b1;
        tick();
        bus.clr_err_i = 1'b0;
        go(gi, 2);
        chk("clr_set_err", bus.err_o, 1);
        chk("clr_set_cnt", bus.err_cnt_o, 1);
        go(0, 4);
        bus.en_i = 1'b0;
        go(1, 4);
        go(2, 4);
        chk("dis_phase", bus.phase_o, 2);
        bus.en_i = 1'b1;
        go(2, 4);
        go(3, 4);
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            bus.en_i = ($urandom_range(0, 7) != 0);
            bus.clr_err_i = ($urandom_range(0, 15) == 0);
            go(r < 5 ? gi + 1 : r < 7 ? gi + 3 : r < 8 ? gi + 2 : gi, 1);
        end
        bus.en_i = 1'b1;
        bus.clr_err_i = 1'b0;
        do_reset(0);
        go(0, 6);
        for (int i = 0; i < 8'h37; i++) go(gi + 1, 1);
        go(gi, 3);
        chk("run_pos", bus.pos_o, 8'h37);
        do_reset(gi);
        go(gi, 8);
        go(gi + 1, 4);
        chk("reprime_pos", bus.pos_o, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
